// File: rtl/cv32e40p_pkg2_ft.sv
// Shared types and default tuning constants for the fault-tolerant CV32E40P replica supervisor.
package cv32e40p_pkg2_ft;

    typedef enum logic [1:0] {
        REPLICA_OK        = 2'd0,
        REPLICA_SUSPECT   = 2'd1,
        REPLICA_BROKEN    = 2'd2,
        REPLICA_PROBATION = 2'd3
    } replica_state_e;

    localparam int CODE_INCREMENT          = 4;
    localparam int CODE_DECREMENT          = 1;
    localparam int CODE_BREAKING_THRESHOLD = 12;
    localparam int CODE_COUNT_BIT          = 4;
    localparam int CODE_PROBATION_LEN      = 8;

endpackage

// File: rtl/cv32e40p_ft_replica_health.sv
// Per-replica health tracker: leaky-bucket error counter, probation counter and state FSM.
module cv32e40p_ft_replica_health
    import cv32e40p_pkg2_ft::*;
#(
    parameter int COUNT_BIT          = CODE_COUNT_BIT,
    parameter int INCREMENT          = CODE_INCREMENT,
    parameter int DECREMENT          = CODE_DECREMENT,
    parameter int BREAKING_THRESHOLD = CODE_BREAKING_THRESHOLD,
    parameter int PROBATION_LEN      = CODE_PROBATION_LEN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_i,
    input  logic           err_i,
    input  logic           set_broken_i,
    input  logic           clear_broken_i,
    output replica_state_e state_o,
    output logic           is_broken_o
);

    localparam int PW = $clog2(PROBATION_LEN + 1);
    localparam logic [COUNT_BIT:0] CNT_MAX = (COUNT_BIT + 1)'((1 << COUNT_BIT) - 1);
    localparam logic [COUNT_BIT:0] CNT_THR = (COUNT_BIT + 1)'(BREAKING_THRESHOLD);

    replica_state_e         state_reg, state_next;
    logic [COUNT_BIT-1:0]   count_reg, count_next;
    logic [PW-1:0]          prob_reg, prob_next;
    logic [COUNT_BIT:0]     count_inc;
    logic [PW-1:0]          prob_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= REPLICA_OK;
            count_reg <= '0;
            prob_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            prob_reg  <= prob_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        prob_next  = prob_reg;
        count_inc  = {1'b0, count_reg} + (COUNT_BIT + 1)'(INCREMENT);
        if (count_inc > CNT_MAX) begin
            count_inc = CNT_MAX;
        end
        prob_inc   = prob_reg + PW'(1);

        // Forced break wins over everything; the count is left frozen for inspection.
        if (set_broken_i) begin
            state_next = REPLICA_BROKEN;
        end else begin
            case (state_reg)
                REPLICA_OK, REPLICA_SUSPECT: begin
                    if (valid_i && err_i) begin
                        count_next = count_inc[COUNT_BIT-1:0];
                        state_next = (count_inc >= CNT_THR) ? REPLICA_BROKEN : REPLICA_SUSPECT;
                    end else if (valid_i && state_reg == REPLICA_SUSPECT) begin
                        if (count_reg > COUNT_BIT'(DECREMENT)) begin
                            count_next = count_reg - COUNT_BIT'(DECREMENT);
                        end else begin
                            count_next = '0;
                            state_next = REPLICA_OK;
                        end
                    end
                end
                REPLICA_BROKEN: begin
                    if (clear_broken_i) begin
                        state_next = REPLICA_PROBATION;
                        count_next = '0;
                        prob_next  = '0;
                    end
                end
                REPLICA_PROBATION: begin
                    if (valid_i) begin
                        if (err_i) begin
                            state_next = REPLICA_BROKEN;
                        end else if (prob_inc == PW'(PROBATION_LEN)) begin
                            state_next = REPLICA_OK;
                            prob_next  = '0;
                        end else begin
                            prob_next  = prob_inc;
                        end
                    end
                end
                default: state_next = REPLICA_OK;
            endcase
        end
    end

    assign state_o     = state_reg;
    assign is_broken_o = (state_reg == REPLICA_BROKEN) || (state_reg == REPLICA_PROBATION);

endmodule

// File: rtl/cv32e40p_ft_replica_supervisor.sv
// TMR voter with per-replica health supervision and duplex/simplex degradation.
// Optional error logging is enabled by defining CV32E40P_FT_ERR_LOG_EN.
module cv32e40p_ft_replica_supervisor
    import cv32e40p_pkg2_ft::*;
#(
    parameter int WIDTH              = 32,
    parameter int NCH                = 3,
    parameter int COUNT_BIT          = CODE_COUNT_BIT,
    parameter int INCREMENT          = CODE_INCREMENT,
    parameter int DECREMENT          = CODE_DECREMENT,
    parameter int BREAKING_THRESHOLD = CODE_BREAKING_THRESHOLD,
    parameter int PROBATION_LEN      = CODE_PROBATION_LEN
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              valid_i,
    input  logic [2:0][NCH-1:0][WIDTH-1:0]    to_vote_i,
    input  logic [2:0]                        set_broken_i,
    input  logic [2:0]                        clear_broken_i,
    output logic [NCH-1:0][WIDTH-1:0]         voted_o,
    output logic                              voted_valid_o,
    output logic [2:0]                        is_broken_o,
    output logic                              err_detected_o,
    output logic                              err_corrected_o,
    output logic                              uncorrectable_o,
    output logic [15:0]                       err_count_o
);

    replica_state_e              state [3];
    logic [2:0]                  broken;
    logic [2:0]                  active;
    logic [2:0]                  in_prob;
    logic [2:0]                  diff;
    logic [2:0]                  rep_err;
    logic [1:0]                  n_act;
    logic                        pair_mm;
    logic                        uncorr_comb;
    logic                        det_comb;
    logic [NCH-1:0][WIDTH-1:0]   maj;
    logic [NCH-1:0][WIDTH-1:0]   voted_comb;

    logic [NCH-1:0][WIDTH-1:0]   voted_reg;
    logic                        voted_valid_reg;
    logic                        det_reg, corr_reg, uncorr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_health
            cv32e40p_ft_replica_health #(
                .COUNT_BIT          (COUNT_BIT),
                .INCREMENT          (INCREMENT),
                .DECREMENT          (DECREMENT),
                .BREAKING_THRESHOLD (BREAKING_THRESHOLD),
                .PROBATION_LEN      (PROBATION_LEN)
            ) u_health (
                .clk            (clk),
                .rst_n          (rst_n),
                .valid_i        (valid_i),
                .err_i          (rep_err[gi]),
                .set_broken_i   (set_broken_i[gi]),
                .clear_broken_i (clear_broken_i[gi]),
                .state_o        (state[gi]),
                .is_broken_o    (broken[gi])
            );
            assign active[gi]  = ~broken[gi];
            assign in_prob[gi] = (state[gi] == REPLICA_PROBATION);
            assign diff[gi]    = (to_vote_i[gi] != voted_comb);
        end
    endgenerate

    assign maj   = (to_vote_i[0] & to_vote_i[1]) | (to_vote_i[0] & to_vote_i[2])
                 | (to_vote_i[1] & to_vote_i[2]);
    assign n_act = {1'b0, active[0]} + {1'b0, active[1]} + {1'b0, active[2]};

    always_comb begin
        voted_comb = to_vote_i[0];
        case (n_act)
            2'd3:    voted_comb = maj;
            2'd2:    voted_comb = active[0] ? to_vote_i[0] : to_vote_i[1];
            2'd1:    voted_comb = active[0] ? to_vote_i[0] :
                                  (active[1] ? to_vote_i[1] : to_vote_i[2]);
            default: voted_comb = to_vote_i[0];
        endcase
    end

    // In duplex the unchosen active replica is the only one that can differ; a mismatch blames both.
    always_comb begin
        pair_mm = (n_act == 2'd2) && |(diff & active);
        rep_err = '0;
        for (int i = 0; i < 3; i++) begin
            if (in_prob[i]) begin
                rep_err[i] = diff[i];
            end else if (active[i]) begin
                rep_err[i] = (n_act == 2'd2) ? pair_mm : diff[i];
            end
        end
        uncorr_comb = (n_act == 2'd0) || pair_mm;
        det_comb    = (|rep_err) || (n_act == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voted_reg       <= '0;
            voted_valid_reg <= 1'b0;
            det_reg         <= 1'b0;
            corr_reg        <= 1'b0;
            uncorr_reg      <= 1'b0;
        end else begin
            voted_valid_reg <= valid_i;
            det_reg         <= valid_i && det_comb;
            corr_reg        <= valid_i && det_comb && !uncorr_comb;
            uncorr_reg      <= valid_i && uncorr_comb;
            if (valid_i) begin
                voted_reg <= voted_comb;
            end
        end
    end

    assign voted_o         = voted_reg;
    assign voted_valid_o   = voted_valid_reg;
    assign is_broken_o     = broken;
    assign err_detected_o  = det_reg;
    assign err_corrected_o = corr_reg;
    assign uncorrectable_o = uncorr_reg;

`ifdef CV32E40P_FT_ERR_LOG_EN
    logic [15:0] err_count_reg;
    logic [2:0]  last_syndrome_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg     <= '0;
            last_syndrome_reg <= '0;
        end else if (valid_i && det_comb) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            last_syndrome_reg <= rep_err;
        end
    end

    assign err_count_o = err_count_reg;
`else
    assign err_count_o = '0;
`endif

endmodule
